// File: rtl/interrupt_request_register_if.sv
// Bundle between the PIC controller (master) and the interrupt request register block (slave).
interface interrupt_request_register_if;
  logic [7:0] interrupt_request_pin;
  logic       write_initial_command_word_1;
  logic       level_or_edge_triggered_config;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] interrupt_mask;
  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic [7:0] interrupt_request_register;
  logic [7:0] interrupt;
  logic       interrupt_pending;

  modport master (
    output interrupt_request_pin, write_initial_command_word_1,
           level_or_edge_triggered_config, freeze, clear_interrupt_request,
           interrupt_mask, in_service_register, priority_rotate,
    input  interrupt_request_register, interrupt, interrupt_pending
  );

  modport slave (
    input  interrupt_request_pin, write_initial_command_word_1,
           level_or_edge_triggered_config, freeze, clear_interrupt_request,
           interrupt_mask, in_service_register, priority_rotate,
    output interrupt_request_register, interrupt, interrupt_pending
  );
endinterface

// File: rtl/interrupt_request_register.sv
// PIC request latch and rotating-priority resolver; presents a registered one-hot winner.
// Define IRR_INPUT_SYNC_EN to add a two-flop synchroniser on each IR pin (+2 clk latency).
module interrupt_request_register (
  input logic                         clk,
  input logic                         reset_n,
  interrupt_request_register_if.slave bus
);
  localparam int IRQ_WIDTH = 8;

  logic [7:0] sample;
  logic [7:0] edge_history;
  logic [7:0] irr;
  logic [7:0] irr_next;
  logic [7:0] interrupt_q;
  logic [7:0] req;
  logic [7:0] winner;
  logic [2:0] lvl;
  logic       done;

`ifdef IRR_INPUT_SYNC_EN
  logic [7:0] sync_q1;
  logic [7:0] sync_q2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.interrupt_request_pin;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2;
`else
  assign sample = bus.interrupt_request_pin;
`endif

  // Clear beats freeze beats the pin; a request must stay asserted until acknowledged
  always_comb begin
    if (bus.write_initial_command_word_1)
      irr_next = '0;
    else if (bus.freeze)
      irr_next = irr & ~bus.clear_interrupt_request;
    else if (bus.level_or_edge_triggered_config)
      irr_next = sample & ~bus.clear_interrupt_request;
    else
      irr_next = sample & (irr | ~edge_history) & ~bus.clear_interrupt_request;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irr          <= '0;
      edge_history <= 8'hFF;
    end else begin
      irr          <= irr_next;
      edge_history <= bus.write_initial_command_word_1 ? 8'hFF : sample;
    end
  end

  assign req = irr & ~bus.interrupt_mask;

  // Walk from highest to lowest priority; an in-service level stops the search before its request
  always_comb begin
    winner = '0;
    done   = 1'b0;
    lvl    = '0;
    for (int p = 1; p <= IRQ_WIDTH; p++) begin
      lvl = bus.priority_rotate + 3'(p);
      if (!done) begin
        if (bus.in_service_register[lvl]) begin
          done = 1'b1;
        end else if (req[lvl]) begin
          winner[lvl] = 1'b1;
          done        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      interrupt_q <= '0;
    else if (bus.write_initial_command_word_1)
      interrupt_q <= '0;
    else if (!bus.freeze)
      interrupt_q <= winner;
  end

  assign bus.interrupt_request_register = irr;
  assign bus.interrupt                  = interrupt_q;
  assign bus.interrupt_pending          = |interrupt_q;
endmodule
